// File: rtl/jpeg_unstuff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_unstuff_pkg
// Brief    : State encoding and JPEG marker constants for the byte unstuffer.
// Revision : 1.0
// ============================================================================
package jpeg_unstuff_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_FF   = 2'd1,
        S_DONE = 2'd2
    } unstuff_state_t;

    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] STUFF         = 8'h00;
    localparam logic [7:0] EOI           = 8'hD9;
    localparam logic [7:0] RST_BASE      = 8'hD0;
    localparam logic [7:0] RST_IDX_MASK  = 8'h07;
    localparam logic [7:0] PAD_BYTE      = 8'hFF;

    // RSTn markers occupy D0..D7: compare with the index bits masked off.
    function automatic logic is_rst_marker(input logic [7:0] b);
        return (b & ~RST_IDX_MASK) == RST_BASE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_byte_unstuff_if.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_byte_unstuff_if
// Brief    : Valid/accept byte stream with last flag.
// Revision : 1.0
// ============================================================================
interface jpeg_byte_unstuff_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       accept;

    modport master (output valid, output data, output last, input accept);
    modport slave  (input valid, input data, input last, output accept);
endinterface
`default_nettype wire

// File: rtl/jpeg_byte_unstuff.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_byte_unstuff
// Brief    : Removes JPEG byte stuffing/fill bytes, strips RSTn markers and
//            terminates the entropy-coded segment with one last-tagged beat.
// Revision : 1.0
// ============================================================================
module jpeg_byte_unstuff
    import jpeg_unstuff_pkg::*;
#(
    parameter int SUPPORT_RST = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       img_start_i,
    jpeg_byte_unstuff_if.slave         inport,
    jpeg_byte_unstuff_if.master        outport,
    output logic                       restart_o,
    output logic                       marker_err_o
);

    unstuff_state_t r_state;
    unstuff_state_t w_state_nxt;

    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic       r_out_last;
    logic       r_restart;
    logic       r_marker_err;

    logic       w_in_accept;
    logic       w_fire;
    logic       w_emit;
    logic [7:0] w_emit_data;
    logic       w_emit_last;
    logic       w_restart;
    logic       w_err_set;

    always_comb begin
        w_in_accept = 1'b0;
        if (!rst_i && !img_start_i) begin
            w_in_accept = (r_state == S_DONE) ? 1'b1
                                              : (!r_out_valid || outport.accept);
        end
    end

    assign w_fire = inport.valid && w_in_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_data = inport.data;
        w_emit_last = 1'b0;
        w_restart   = 1'b0;
        w_err_set   = 1'b0;

        if (w_fire) begin
            case (r_state)
                S_DATA: begin
                    if (inport.data == MARKER_PREFIX) begin
                        w_state_nxt = S_FF;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                S_FF: begin
                    if (inport.data == STUFF) begin
                        w_emit      = 1'b1;
                        w_emit_data = MARKER_PREFIX;
                        w_state_nxt = S_DATA;
                    end else if (inport.data == MARKER_PREFIX) begin
                        w_state_nxt = S_FF;
                    end else if ((SUPPORT_RST != 0) && is_rst_marker(inport.data)) begin
                        w_restart   = 1'b1;
                        w_state_nxt = S_DATA;
                    end else begin
                        // EOI ends cleanly; any other marker ends with an error.
                        w_emit      = 1'b1;
                        w_emit_data = PAD_BYTE;
                        w_emit_last = 1'b1;
                        w_err_set   = (inport.data != EOI);
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_state_nxt = S_DONE;
                end
            endcase

            // A last byte that produced no beat still has to close the image.
            if (inport.last && (r_state != S_DONE)) begin
                if (!w_emit) begin
                    w_emit_data = PAD_BYTE;
                end
                w_emit      = 1'b1;
                w_emit_last = 1'b1;
                w_state_nxt = S_DONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || img_start_i) begin
            r_state      <= S_DATA;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_last   <= 1'b0;
            r_restart    <= 1'b0;
            r_marker_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_restart <= w_restart;
            if (w_err_set) begin
                r_marker_err <= 1'b1;
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_emit_data;
                r_out_last  <= w_emit_last;
            end else if (outport.accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign inport.accept  = w_in_accept;
    assign outport.valid  = r_out_valid;
    assign outport.data   = r_out_data;
    assign outport.last   = r_out_last;
    assign restart_o      = r_restart;
    assign marker_err_o   = r_marker_err;

endmodule
`default_nettype wire

// File: doc/jpeg_byte_unstuff.md
# jpeg_byte_unstuff

Byte-stream front end for the entropy-coded segment, sitting directly upstream of jpeg_bitbuffer. It removes JPEG byte stuffing (0xFF 0x00 → 0xFF) and fill bytes, and strips RSTn markers, signalling each with a pulse. It terminates the segment on EOI, on any other marker or on the input last flag, emitting exactly one final beat tagged last. The output is a registered 1-entry stage whose outport maps onto the bitbuffer inport.

## Interface
- SUPPORT_RST, default 1: when 1, FFD0–FFD7 are stripped and pulse restart_o; when 0, they are treated as unexpected markers.
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- img_start_i  input  1  per-image restart; clears state, output register and flags.
- inport_valid_i  input  1  raw byte valid.
- inport_data_i  input  8  raw entropy-coded byte.
- inport_last_i  input  1  final raw byte of the image; qualified by valid.
- inport_accept_o  output  1  byte accepted when valid && accept.
- outport_valid_o  output  1  unstuffed byte valid.
- outport_data_o  output  8  unstuffed byte.
- outport_last_o  output  1  final beat of image; qualified by valid.
- outport_accept_i  input  1  downstream accept; connects to jpeg_bitbuffer inport_accept_o.
- restart_o  output  1  one-cycle pulse per stripped RSTn marker.
- marker_err_o  output  1  sticky: unexpected marker terminated the segment.

## Operation
- States: S_DATA (normal), S_FF (0xFF seen, pending), S_DONE (terminated, discarding).
- S_DATA, byte != 0xFF: emit the byte; stay in S_DATA.
- S_DATA, byte == 0xFF: emit nothing; go to S_FF.
- S_FF, byte 0x00: emit 0xFF; go to S_DATA.
- S_FF, byte 0xFF: fill byte; emit nothing; stay in S_FF.
- S_FF, byte 0xD0–0xD7 with SUPPORT_RST=1: emit nothing; pulse restart_o the next cycle; go to S_DATA.
- S_FF, byte 0xD9 (EOI): emit pad byte 0xFF with last=1; go to S_DONE.
- S_FF, any other byte: emit pad 0xFF with last=1; set marker_err_o; go to S_DONE.
- inport_last_i on an accepted byte:
  - if that byte emits a beat, the beat carries last=1;
  - otherwise (0xFF start, fill, RST), emit pad 0xFF with last=1;
  - in all cases go to S_DONE.
- The pad byte 0xFF is legal Huffman 1-padding; downstream stops on block count.
- S_DONE: inport_accept_o=1; all bytes discarded; no outputs. Exits only on img_start_i or rst_i.
- Exactly one last=1 beat per image. No beat follows it.

## Timing
- Reset and img_start_i values: state S_DATA; outport_valid_o, outport_data_o, outport_last_o, restart_o and marker_err_o all 0.
- rst_i has priority over img_start_i, and img_start_i over input. While either is high, inport_accept_o=0 and a pending output beat is dropped.
- Otherwise inport_accept_o:
  - 1 in S_DONE;
  - else (!outport_valid_o || outport_accept_i).
- Latency is 1 cycle from an accepted input byte to outport_valid_o. Throughput is 1 byte/cycle with outport_accept_i held high.
- Output register:
  - holds data and last stable while valid && !accept;
  - loads a new beat in the same cycle the old one is accepted;
  - clears valid when the old beat is accepted and no new beat is produced.
- The backpressure path inport_accept_o depends combinationally on outport_accept_i. There is no combinational path from inport_* to outport_*.
- restart_o asserts in the cycle after the RSTn byte is accepted, for one cycle, independent of backpressure.
- Simultaneous inport_last_i with a stuffed 0x00: emit 0xFF with last=1.

## Structure
- Shared package jpeg_unstuff_pkg holds:
  - state encoding S_DATA/S_FF/S_DONE;
  - constants MARKER_PREFIX=8'hFF, STUFF=8'h00, EOI=8'hD9, RST_BASE=8'hD0 with a 3-bit index mask;
  - PAD_BYTE=8'hFF.
- No sub-module. The FSM and the 1-entry output register stay inline, since the block is small.

## Test plan
- Input 12 FF 00 34 FF D9, accept held 1 → output 12, FF, 34, FF(last=1), then S_DONE; marker_err_o=0.
- Input AB FF FF FF 00 CD with last on CD → output AB, FF, CD(last=1); fill bytes dropped.
- Input 01 FF D3 02 with SUPPORT_RST=1 → output 01, 02; restart_o pulses once, one cycle after D3. With SUPPORT_RST=0 → output 01, FF(last=1); marker_err_o=1; 02 accepted and discarded.
- Backpressure: hold outport_accept_i=0 for 5 cycles with a beat pending → data stable, inport_accept_o=0. Release → one beat/cycle, no loss or duplication over a 64-byte random stream (stuffing ratio 25%), checked against a reference unstuffer model.
- img_start_i mid-stream with a beat pending and the FSM in S_FF → next cycle outport_valid_o=0, flags 0, state S_DATA. A following 00 byte is emitted as 00, not FF.
- Input FF with inport_last_i → single pad FF(last=1); a subsequent FF D9 is discarded with no output.
